uart_cmd_router: RTL
====================

# uart_cmd_router

Parametrised UART command router that sits between the UART receiver and the per-mode function blocks (watch, stopwatch, ultrasonic, DHT11 and later additions). It selects one of `NUM_CH` channels from the board switches or from UART select commands. It turns UART command bytes into stretched button pulses on the selected channel, and raises a UART-initiated soft reset. A one-entry pending buffer decouples byte arrival from pulse generation; bytes that cannot be buffered are dropped and flagged.

## Interface
Parameters:
- `NUM_CH`, 4, number of channels, 2..10
- `BTN_W`, 4, buttons per channel, 1..8
- `PULSE_CYCLES`, 1, high time of each button pulse in clk cycles, ≥1
- `GAP_CYCLES`, 1, low time enforced after each pulse, ≥1
- derived localparam `SEL_W` = max(1, $clog2(NUM_CH))

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  async active-high reset
- `i_sw`  in  SEL_W  switch-requested channel
- `rx_done`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `o_sel`  out  SEL_W  active channel
- `o_btn`  out  NUM_CH*BTN_W  button pulses; channel c, button k at bit c*BTN_W+k
- `o_uart_reset`  out  1  one-cycle soft-reset pulse
- `o_busy`  out  1  pending byte held or FSM not IDLE
- `o_drop`  out  1  one-cycle pulse, byte lost

## Operation
- Reset values: `o_sel`=0, `o_btn`=0, `o_uart_reset`=0, `o_busy`=0, `o_drop`=0, pending empty, FSM IDLE, switch history register = 0.
- Pending buffer: `rx_done` stores `rx_data` if the buffer is empty or is being popped in the same cycle. Otherwise the byte is discarded and `o_drop` pulses the next cycle.
- Byte decode, performed in IDLE when pending is valid (pop):
  - `'0'`+n with n<NUM_CH: `o_sel`<=n. n≥NUM_CH is ignored.
  - `'!'` (0x21): `o_uart_reset` pulses one cycle. `o_sel` is unchanged.
  - `'a'`+k or `'A'`+k with k<BTN_W: latch channel=`o_sel`, button=k, go to PULSE.
  - Any other byte: discarded silently. Stays IDLE.
- Switch select: when `i_sw` differs from its registered previous value, `o_sel`<=`i_sw` (if <NUM_CH; otherwise ignored). If a switch change and a UART select happen in the same cycle, the switch wins.
- FSM:
  - IDLE→PULSE on a button command.
  - PULSE drives exactly one `o_btn` bit for PULSE_CYCLES cycles, then goes to GAP.
  - GAP keeps all outputs low for GAP_CYCLES cycles, then returns to IDLE.
- The pulse uses the latched channel. `o_sel` changes during PULSE/GAP do not move it.
- Bytes arriving during PULSE/GAP: the first is held in the buffer; further ones are dropped.
- `rst` asserted mid-pulse clears everything immediately (async). No pulse resumes after release.

## Timing
- `rx_done` at cycle t → pending valid at t+1 → decoded at t+1.
- Select takes effect on `o_sel` at t+2.
- `o_uart_reset` is high during cycle t+2 only.
- `o_btn` bit is high from t+2 through t+1+PULSE_CYCLES.
- Back-to-back button bytes: the next pulse rises PULSE_CYCLES+GAP_CYCLES+1 cycles after the previous rise.
- Switch change sampled at t → `o_sel` updated at t+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_cmd_pkg`:
  - ASCII constants: `CMD_SEL_BASE`='0', `CMD_BTN_LO`='a', `CMD_BTN_UP`='A', `CMD_RESET`='!'
  - FSM state enum {IDLE, PULSE, GAP}
- Sub-module `uart_cmd_decode`: combinational byte → {kind, index} classification. The top level holds the buffer, FSM, counters and the select register.

## Test plan
- Reset, then byte `'b'` (NUM_CH=4, BTN_W=4, PULSE_CYCLES=3) → `o_btn`[1] high for exactly 3 cycles starting 2 cycles after `rx_done`; all other bits are 0.
- `'2'` then `'c'` → `o_sel`=2, then `o_btn`[10] pulses. A following `'7'` leaves `o_sel`=2.
- Three `rx_done` bytes `'a'`,`'b'`,`'c'` on consecutive cycles:
  - `'a'` pulses.
  - `'b'` is buffered and pulses after the gap.
  - `'c'` raises `o_drop` once.
- `i_sw` 0→3 in the same cycle the `'1'` pop occurs → `o_sel`=3.
- `'!'` → `o_uart_reset` high exactly one cycle; `o_sel` and `o_btn` are unaffected.
- `rst` asserted mid-PULSE → `o_btn`=0 asynchronously. After release, `o_busy`=0 and no residual pulse appears.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and enums for the UART command router and its byte decoder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_SEL_BASE = 8'h30;  // '0'
  localparam logic [7:0] CMD_BTN_LO   = 8'h61;  // 'a'
  localparam logic [7:0] CMD_BTN_UP   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_RESET    = 8'h21;  // '!'

  // Wide enough for a channel index (up to 10) or a button index (up to 8).
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  typedef enum logic [1:0] {KIND_NONE, KIND_SEL, KIND_BTN, KIND_RST} kind_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Combinational classification of a command byte into {kind, index}.
// Out-of-range select/button indices decode as KIND_NONE.
module uart_cmd_decode
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BTN_W  = 4
) (
  input  logic [7:0]       rx_byte,
  output kind_t            kind,
  output logic [IDX_W-1:0] idx
);

  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);
  localparam logic [7:0] BTN_W_B  = 8'(BTN_W);

  logic [7:0] sel_off;
  logic [7:0] lo_off;
  logic [7:0] up_off;

  // Unsigned wrap makes bytes below each base land far out of range.
  assign sel_off = rx_byte - CMD_SEL_BASE;
  assign lo_off  = rx_byte - CMD_BTN_LO;
  assign up_off  = rx_byte - CMD_BTN_UP;

  always_comb begin
    kind = KIND_NONE;
    idx  = '0;
    if (rx_byte == CMD_RESET) begin
      kind = KIND_RST;
    end else if (sel_off < NUM_CH_B) begin
      kind = KIND_SEL;
      idx  = sel_off[IDX_W-1:0];
    end else if (lo_off < BTN_W_B) begin
      kind = KIND_BTN;
      idx  = lo_off[IDX_W-1:0];
    end else if (up_off < BTN_W_B) begin
      kind = KIND_BTN;
      idx  = up_off[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/uart_cmd_router.sv
// Routes UART command bytes to channel select, stretched button pulses and soft reset.
// One-entry pending buffer; bytes arriving while it is full and not popping are dropped.
module uart_cmd_router
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int BTN_W        = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1,
  localparam int SEL_W       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        i_sw,
  input  logic                    rx_done,
  input  logic [7:0]              rx_data,
  output logic [SEL_W-1:0]        o_sel,
  output logic [NUM_CH*BTN_W-1:0] o_btn,
  output logic                    o_uart_reset,
  output logic                    o_busy,
  output logic                    o_drop
);

  localparam int BTN_TOT = NUM_CH * BTN_W;
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               pend_vld;
  logic [7:0]         pend_dat;
  logic [SEL_W-1:0]   sw_prev;

  kind_t              dec_kind;
  logic [IDX_W-1:0]   dec_idx;

  logic               pop;
  logic               push;
  logic               pend_vld_nxt;
  logic               sw_take;
  logic               fsm_busy_nxt;
  logic [BTN_TOT-1:0] btn_vec;

  uart_cmd_decode #(
    .NUM_CH (NUM_CH),
    .BTN_W  (BTN_W)
  ) u_decode (
    .rx_byte (pend_dat),
    .kind    (dec_kind),
    .idx     (dec_idx)
  );

  assign pop          = pend_vld && (state == IDLE);
  assign push         = rx_done && (!pend_vld || pop);
  assign pend_vld_nxt = push || (pend_vld && !pop);
  assign sw_take      = (i_sw != sw_prev) && (int'(i_sw) < NUM_CH);
  assign btn_vec      = BTN_TOT'(1) << (int'(o_sel) * BTN_W + int'(dec_idx));

  // Next-cycle FSM occupancy, so o_busy can be registered like every other output.
  always_comb begin
    fsm_busy_nxt = 1'b1;
    case (state)
      IDLE:    fsm_busy_nxt = pop && (dec_kind == KIND_BTN);
      GAP:     fsm_busy_nxt = (cnt != '0);
      default: fsm_busy_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_vld     <= 1'b0;
      pend_dat     <= '0;
      sw_prev      <= '0;
      o_sel        <= '0;
      o_btn        <= '0;
      o_uart_reset <= 1'b0;
      o_busy       <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_uart_reset <= pop && (dec_kind == KIND_RST);
      o_drop       <= rx_done && !push;
      o_busy       <= pend_vld_nxt || fsm_busy_nxt;
      sw_prev      <= i_sw;
      pend_vld     <= pend_vld_nxt;
      if (push) pend_dat <= rx_data;

      // A fresh switch movement overrides a UART select in the same cycle.
      if (sw_take) begin
        o_sel <= i_sw;
      end else if (pop && (dec_kind == KIND_SEL)) begin
        o_sel <= dec_idx[SEL_W-1:0];
      end

      // o_btn itself holds the latched channel/button for the whole pulse.
      case (state)
        IDLE: begin
          if (pop && (dec_kind == KIND_BTN)) begin
            state <= PULSE;
            cnt   <= PULSE_LD;
            o_btn <= btn_vec;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LD;
            o_btn <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          o_btn <= '0;
        end
      endcase
    end
  end

endmodule
